// File: rtl/axi4_lite_pkg.sv
// AXI4-Lite RAM slave shared types.
// Response codes and FSM state encodings.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACK,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACK,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle.
// Master and slave views of the five channels.
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport m (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport s (
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi4_lite_ram_array.sv
// Word array with byte-enable write port.
// Combinational read, cleared while reset is high.
module axi4_lite_ram_array #(
    parameter int DW    = 64,
    parameter int DEPTH = 256,
    localparam int MW   = $clog2(DEPTH)
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            we,
    input  logic [MW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic [MW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Clear everything on reset, otherwise merge strobed bytes.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int k = 0; k < DW / 8; k++) begin
                if (wstrb[k]) begin
                    mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite RAM slave endpoint.
// Independent read and write FSMs, SLVERR outside the window.
module axi4_lite_ram_slave
    import axi4_lite_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 64,
    parameter int DEPTH    = 256,
    parameter int ADDR_LSB = 0,
    parameter int SAW      = 29
) (
    input logic     aclk,
    input logic     aresetn,
    axi4_lite_if.s  bus
);

    localparam int IW = SAW - ADDR_LSB;
    localparam int MW = $clog2(DEPTH);

    wr_state_t     w_state;
    wr_state_t     w_next;
    rd_state_t     r_state;
    rd_state_t     r_next;

    logic [IW-1:0] aw_idx;
    logic [IW-1:0] ar_idx;
    logic          aw_hit;
    logic          ar_hit;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    resp_t         bresp_q;
    resp_t         rresp_q;
    logic [DW-1:0] rdata_q;

    assign aw_idx = IW'(bus.awaddr >> ADDR_LSB);
    assign ar_idx = IW'(bus.araddr >> ADDR_LSB);
    assign aw_hit = aw_idx < IW'(DEPTH);
    assign ar_hit = ar_idx < IW'(DEPTH);
    assign ram_we = (w_state == W_ACK) && aw_hit;

    axi4_lite_ram_array #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .aclk    (aclk),
        .aresetn (aresetn),
        .we      (ram_we),
        .waddr   (aw_idx[MW-1:0]),
        .wdata   (bus.wdata),
        .wstrb   (bus.wstrb),
        .raddr   (ar_idx[MW-1:0]),
        .rdata   (ram_rdata)
    );

    // Write FSM state register.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    // Write FSM: accept AW and W together, then hold B.
    always_comb begin
        w_next      = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (bus.awvalid && bus.wvalid) w_next = W_ACK;
            end
            W_ACK: begin
                bus.awready = 1'b1;
                bus.wready  = 1'b1;
                w_next      = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Latch the write response on the AW/W handshake edge.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            bresp_q <= OKAY;
        end else if (w_state == W_ACK) begin
            bresp_q <= aw_hit ? OKAY : SLVERR;
        end
    end

    assign bus.bresp = bresp_q;

    // Read FSM state register.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    // Read FSM: one-cycle arready, then hold R.
    always_comb begin
        r_next      = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (bus.arvalid) r_next = R_ACK;
            end
            R_ACK: begin
                bus.arready = 1'b1;
                r_next      = R_DATA;
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                if (bus.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Capture read data before any same-edge write lands.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (r_state == R_ACK) begin
            rdata_q <= ar_hit ? ram_rdata : '0;
            rresp_q <= ar_hit ? OKAY : SLVERR;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.rresp = rresp_q;

endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// Directed bench for the AXI4-Lite RAM slave.
// Inputs driven 1ns after rising edges, outputs sampled there too.
module tb_axi4_lite_ram_slave;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   checks  = 0;
    int   fails   = 0;

    always #5 aclk = ~aclk;

    axi4_lite_if #(.AW(32), .DW(64)) bus ();

    axi4_lite_ram_slave #(
        .AW(32), .DW(64), .DEPTH(256), .ADDR_LSB(0), .SAW(29)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    task automatic axi_write(input logic [31:0] a, input logic [63:0] d,
                             input logic [7:0] s, output logic [1:0] resp);
        int n;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        do begin
            @(posedge aclk); #1; n++;
        end while (!(bus.awready && bus.wready) && n < 20);
        checks++;
        if (n !== 1) begin
            fails++;
            $display("FAIL write_accept addr=%h cycles=%0d required 1", a, n);
        end
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1) begin
            fails++;
            $display("FAIL b_latency addr=%h bvalid=%b required 1", a, bus.bvalid);
        end
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [63:0] d,
                            output logic [1:0] resp);
        int n;
        bus.araddr = a; bus.arvalid = 1'b1;
        n = 0;
        do begin
            @(posedge aclk); #1; n++;
        end while (!bus.arready && n < 20);
        checks++;
        if (n !== 1) begin
            fails++;
            $display("FAIL read_accept addr=%h cycles=%0d required 1", a, n);
        end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1) begin
            fails++;
            $display("FAIL r_latency addr=%h rvalid=%b required 1", a, bus.rvalid);
        end
        d = bus.rdata; resp = bus.rresp;
        bus.rready = 1'b1;
        @(posedge aclk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        logic [1:0]  r;
        aresetn = 1'b1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
             bus.bresp, bus.rresp, bus.rdata} !== 73'd0) begin
            fails++;
            $display("FAIL reset_outputs ready/valid=%b%b%b%b%b bresp=%b rresp=%b rdata=%h required all 0",
                     bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                     bus.bresp, bus.rresp, bus.rdata);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        for (int i = 0; i < 256; i++) begin
            axi_read(32'(i), d, r);
            checks++;
            if (d !== 64'd0 || r !== 2'b00) begin
                fails++;
                $display("FAIL reset_read addr=%0d rdata=%h rresp=%b required 0/00", i, d, r);
            end
        end
    endtask

    task automatic test_full_write();
        logic [63:0] d;
        logic [1:0]  r;
        axi_write(32'd5, 64'h5, 8'hFF, r);
        checks++;
        if (r !== 2'b00) begin
            fails++;
            $display("FAIL full_write_bresp got=%b required 00", r);
        end
        axi_read(32'd5, d, r);
        checks++;
        if (d !== 64'h5 || r !== 2'b00) begin
            fails++;
            $display("FAIL full_write_read rdata=%h rresp=%b required 5/00", d, r);
        end
    endtask

    task automatic test_strobe();
        logic [63:0] d;
        logic [1:0]  r;
        axi_write(32'd7, 64'hAABB_CCDD_1122_3344, 8'hFF, r);
        axi_write(32'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, r);
        axi_read(32'd7, d, r);
        checks++;
        if (d !== 64'hAABB_CCDD_FFFF_FFFF) begin
            fails++;
            $display("FAIL strobe_merge rdata=%h required aabbccddffffffff", d);
        end
        axi_write(32'd7, 64'h0000_0000_0000_0000, 8'h30, r);
        axi_read(32'd7, d, r);
        checks++;
        if (d !== 64'hAABB_0000_FFFF_FFFF) begin
            fails++;
            $display("FAIL strobe_mid rdata=%h required aabb0000ffffffff", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] d;
        logic [1:0]  r;
        axi_write(32'h100, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, r);
        checks++;
        if (r !== 2'b10) begin
            fails++;
            $display("FAIL oor_bresp got=%b required 10", r);
        end
        axi_read(32'h100, d, r);
        checks++;
        if (d !== 64'd0 || r !== 2'b10) begin
            fails++;
            $display("FAIL oor_read rdata=%h rresp=%b required 0/10", d, r);
        end
        axi_read(32'h0, d, r);
        checks++;
        if (d !== 64'd0 || r !== 2'b00) begin
            fails++;
            $display("FAIL oor_alias rdata=%h rresp=%b required 0/00", d, r);
        end
        axi_read(32'h1FFF_FFFF, d, r);
        checks++;
        if (d !== 64'd0 || r !== 2'b10) begin
            fails++;
            $display("FAIL oor_top rdata=%h rresp=%b required 0/10", d, r);
        end
    endtask

    task automatic test_window_strip();
        logic [63:0] d;
        logic [1:0]  r;
        axi_write(32'h2000_0003, 64'h3333_0000_0000_3333, 8'hFF, r);
        checks++;
        if (r !== 2'b00) begin
            fails++;
            $display("FAIL window_bresp got=%b required 00", r);
        end
        axi_read(32'd3, d, r);
        checks++;
        if (d !== 64'h3333_0000_0000_3333 || r !== 2'b00) begin
            fails++;
            $display("FAIL window_read rdata=%h rresp=%b required 3333000000003333/00", d, r);
        end
    endtask

    task automatic test_same_edge();
        logic [63:0] d;
        logic [1:0]  r;
        int          n;
        axi_write(32'h20, 64'h1111, 8'hFF, r);
        bus.awaddr = 32'h20; bus.wdata = 64'h2222; bus.wstrb = 8'hFF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h20; bus.arvalid = 1'b1;
        n = 0;
        do begin
            @(posedge aclk); #1; n++;
        end while (!(bus.awready && bus.arready) && n < 20);
        checks++;
        if (n !== 1) begin
            fails++;
            $display("FAIL same_edge_accept cycles=%0d required 1", n);
        end
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.bvalid !== 1'b1 || bus.rdata !== 64'h1111) begin
            fails++;
            $display("FAIL same_edge_old rvalid=%b bvalid=%b rdata=%h required 1/1/1111",
                     bus.rvalid, bus.bvalid, bus.rdata);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 64'h2222) begin
            fails++;
            $display("FAIL same_edge_new rdata=%h required 2222", d);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d;
        logic [1:0]  r;
        int          n;
        bus.awaddr = 32'h10; bus.wdata = 64'h1010; bus.wstrb = 8'hFF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'd5; bus.arvalid = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        bus.awaddr = 32'h11; bus.wdata = 64'h1111_2222; bus.wstrb = 8'hFF;
        bus.araddr = 32'd7;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({bus.bvalid, bus.bresp, bus.rvalid, bus.rresp, bus.awready,
                 bus.wready, bus.arready} !== 9'b1_00_1_00_000 ||
                bus.rdata !== 64'h5) begin
                fails++;
                $display("FAIL hold_cycle%0d bvalid=%b bresp=%b rvalid=%b rresp=%b awready=%b wready=%b arready=%b rdata=%h required 1/00/1/00/0/0/0/5",
                         i, bus.bvalid, bus.bresp, bus.rvalid, bus.rresp,
                         bus.awready, bus.wready, bus.arready, bus.rdata);
            end
            @(posedge aclk); #1;
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        checks++;
        if ({bus.bvalid, bus.rvalid, bus.awready, bus.arready} !== 4'b0000) begin
            fails++;
            $display("FAIL hold_release bvalid=%b rvalid=%b awready=%b arready=%b required 0000",
                     bus.bvalid, bus.rvalid, bus.awready, bus.arready);
        end
        n = 0;
        do begin
            @(posedge aclk); #1; n++;
        end while (!(bus.awready && bus.arready) && n < 20);
        checks++;
        if (n !== 1) begin
            fails++;
            $display("FAIL queued_accept cycles=%0d required 1", n);
        end
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        checks++;
        if (bus.rdata !== 64'hAABB_0000_FFFF_FFFF || bus.bresp !== 2'b00 ||
            bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1) begin
            fails++;
            $display("FAIL queued_resp rdata=%h bresp=%b bvalid=%b rvalid=%b required aabb0000ffffffff/00/1/1",
                     bus.rdata, bus.bresp, bus.bvalid, bus.rvalid);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        axi_read(32'h11, d, r);
        checks++;
        if (d !== 64'h1111_2222) begin
            fails++;
            $display("FAIL queued_write rdata=%h required 11112222", d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] d;
        logic [1:0]  r;
        int          n;
        bus.awaddr = 32'd9; bus.wdata = 64'h9999; bus.wstrb = 8'hFF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        do begin
            @(posedge aclk); #1; n++;
        end while (!bus.awready && n < 20);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_pre bvalid=%b required 1", bus.bvalid);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (bus.bvalid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_drop bvalid=%b required 0", bus.bvalid);
        end
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (bus.bvalid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_after bvalid=%b required 0", bus.bvalid);
        end
        axi_read(32'd9, d, r);
        checks++;
        if (d !== 64'd0 || r !== 2'b00) begin
            fails++;
            $display("FAIL mid_reset_read rdata=%h rresp=%b required 0/00", d, r);
        end
        axi_read(32'd5, d, r);
        checks++;
        if (d !== 64'd0) begin
            fails++;
            $display("FAIL mid_reset_clear rdata=%h required 0", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        #1;
        test_reset();
        test_full_write();
        test_strobe();
        test_out_of_range();
        test_window_strip();
        test_same_edge();
        test_backpressure();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
